// File: rtl/muxn_ser_pkg.sv
// Shared types and helpers for the lane serializer: FSM states, select-width
// derivation and the masked-lane search.
package muxn_ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int MAX_LANES = 64;

   function automatic bit lanes_ok(input int n);
      return (n >= 2) && (n <= MAX_LANES) && ((n & (n - 1)) == 0);
   endfunction

   // Falls back to 1 for an illegal N so elaboration reaches the explicit error.
   function automatic int sel_width(input int n);
      return lanes_ok(n) ? $clog2(n) : 1;
   endfunction

   // Lowest set bit strictly above sel, or -1 when none; sel = -1 finds the lowest.
   function automatic int next_set_idx(input logic [MAX_LANES-1:0] mask, input int sel);
      int idx;
      idx = -1;
      for (int i = MAX_LANES - 1; i >= 0; i--) begin
         if ((i > sel) && mask[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/muxn_serializer_if.sv
// Producer/consumer bundle of the lane serializer; slave is the serializer's
// view, master is the environment driving it.
interface muxn_serializer_if
   import muxn_ser_pkg::*;
#(
   parameter int N     = 8,
   parameter int WIDTH = 8
);
   localparam int SEL_W = sel_width(N);

   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] in_data;
`ifdef MUXN_SER_MASK_EN
   logic [N-1:0]       in_mask;
`endif
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_sel;
   logic               out_last;

   modport slave (
`ifdef MUXN_SER_MASK_EN
      input  in_mask,
`endif
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel, out_last
   );

   modport master (
`ifdef MUXN_SER_MASK_EN
      output in_mask,
`endif
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel, out_last
   );

endinterface

// File: rtl/commonlib_muxn.sv
// N-way combinational mux cell: out_data = lane in_sel. Zero latency, no flow control.
module commonlib_muxn #(
   parameter int N     = 8,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0][WIDTH-1:0] in_data_k,
   input  logic [SEL_W-1:0]        in_sel,
   output logic [WIDTH-1:0]        out_data
);

   assign out_data = in_data_k[in_sel];

endmodule

// File: rtl/muxn_serializer.sv
// Parallel-to-serial lane emitter; first beat the cycle after capture, holds under backpressure,
// accepts the next vector on the last-beat handshake. MUXN_SER_MASK_EN adds per-lane skip mask.
module muxn_serializer
   import muxn_ser_pkg::*;
#(
   parameter int N     = 8,
   parameter int WIDTH = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   muxn_serializer_if.slave   bus
);
   localparam int SEL_W = sel_width(N);

   if (!lanes_ok(N)) begin : g_bad_n
      $error("muxn_serializer: N must be a power of two in [2, %0d]", MAX_LANES);
   end

   state_t                    state_q, state_d;
   logic [SEL_W-1:0]          sel_q, sel_d;
   logic [N-1:0][WIDTH-1:0]   bank_q;
   logic                      last_c;
   logic                      ready_c;
   logic                      capture;

`ifdef MUXN_SER_MASK_EN
   logic [N-1:0]              mask_q;
   logic [MAX_LANES-1:0]      mask_q_ext;
   logic [MAX_LANES-1:0]      mask_in_ext;
   int                        nxt_idx;
   int                        first_idx;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   // Lane bank carries no reset; its contents only matter once SHIFT is entered.
   always_ff @(posedge CLK) begin
      if (capture) begin
         bank_q <= bus.in_data;
`ifdef MUXN_SER_MASK_EN
         mask_q <= bus.in_mask;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
`ifdef MUXN_SER_MASK_EN
      mask_q_ext           = '0;
      mask_q_ext[N-1:0]    = mask_q;
      mask_in_ext          = '0;
      mask_in_ext[N-1:0]   = bus.in_mask;
      nxt_idx              = next_set_idx(mask_q_ext, int'(sel_q));
      first_idx            = next_set_idx(mask_in_ext, -1);
      last_c               = (state_q == SHIFT) && (nxt_idx < 0);
`else
      last_c               = (state_q == SHIFT) && (sel_q == SEL_W'(N - 1));
`endif
      ready_c = (state_q == IDLE) || (last_c && bus.out_ready);
      capture = bus.in_valid && ready_c;

      if (capture) begin
`ifdef MUXN_SER_MASK_EN
         // An empty mask is consumed without producing beats.
         if (first_idx < 0) begin
            state_d = IDLE;
            sel_d   = '0;
         end else begin
            state_d = SHIFT;
            sel_d   = SEL_W'(first_idx);
         end
`else
         state_d = SHIFT;
         sel_d   = '0;
`endif
      end else if ((state_q == SHIFT) && bus.out_ready) begin
         if (last_c) begin
            state_d = IDLE;
         end else begin
`ifdef MUXN_SER_MASK_EN
            sel_d = SEL_W'(nxt_idx);
`else
            sel_d = sel_q + SEL_W'(1);
`endif
         end
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = (state_q == SHIFT);
   assign bus.out_last  = last_c;
   assign bus.out_sel   = sel_q;

   commonlib_muxn #(
      .N     (N),
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_muxn (
      .in_data_k (bank_q),
      .in_sel    (sel_q),
      .out_data  (bus.out_data)
   );

endmodule

// File: tb/tb_muxn_serializer.sv
// Scoreboard bench for muxn_serializer: captured vectors are expanded into expected beats,
// popped and compared on every output handshake; directed checks cover timing and hold.
module tb_muxn_serializer;
   import muxn_ser_pkg::*;

   localparam int N     = 8;
   localparam int WIDTH = 8;
   localparam int SW    = $clog2(N);

   logic clk = 1'b0;
   logic rst;

   muxn_serializer_if #(.N(N), .WIDTH(WIDTH)) bus ();

   muxn_serializer #(.N(N), .WIDTH(WIDTH)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] dat;
      logic [SW-1:0]    sel;
      logic             last;
   } beat_t;

   beat_t        sb_q[$];
   beat_t        exp_b;
   beat_t        push_b;
   logic [N-1:0] mon_m;
   int           n_checks = 0;
   int           n_errors = 0;
   int           beat_cnt = 0;
   int           start_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N*WIDTH-1:0] ramp(input logic [7:0] base);
      logic [N*WIDTH-1:0] r;
      for (int k = 0; k < N; k++) r[k*WIDTH +: WIDTH] = base + 8'(k);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output handshakes are retired before same-cycle captures are queued.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            beat_cnt++;
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 32'd0, 32'd1);
            end else begin
               exp_b = sb_q.pop_front();
               check_eq("beat_dat", 32'(bus.out_data), 32'(exp_b.dat));
               check_eq("beat_sel", 32'(bus.out_sel), 32'(exp_b.sel));
               check_eq("beat_last", 32'(bus.out_last), 32'(exp_b.last));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
`ifdef MUXN_SER_MASK_EN
            mon_m = bus.in_mask;
`else
            mon_m = '1;
`endif
            for (int k = 0; k < N; k++) begin
               if (mon_m[k]) begin
                  push_b.dat  = bus.in_data[k*WIDTH +: WIDTH];
                  push_b.sel  = SW'(k);
                  push_b.last = ((mon_m >> (k + 1)) == '0);
                  sb_q.push_back(push_b);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
`ifdef MUXN_SER_MASK_EN
      bus.in_mask   = '1;
`endif
      repeat (3) step();
      rst = 1'b0;
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
      check_eq("rst_out_sel", 32'(bus.out_sel), 32'd0);
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Single vector, consumer always ready.
      bus.in_data  = ramp(8'h10);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = ramp(8'hEE);
      for (int b = 0; b < N; b++) begin
         check_eq("t1_out_valid", 32'(bus.out_valid), 32'd1);
         check_eq("t1_in_ready", 32'(bus.in_ready), (b == N - 1) ? 32'd1 : 32'd0);
         check_eq("t1_out_data", 32'(bus.out_data), 32'h10 + 32'(b));
         step();
      end
      check_eq("t1_idle", 32'(bus.out_valid), 32'd0);
      check_eq("t1_drain", 32'(sb_q.size()), 32'd0);

      // Backpressure at sel=2 for three cycles.
      bus.in_data  = ramp(8'h10);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      check_eq("bp_sel_reach", 32'(bus.out_sel), 32'd2);
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check_eq("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         check_eq("bp_hold_data", 32'(bus.out_data), 32'h12);
         check_eq("bp_hold_sel", 32'(bus.out_sel), 32'd2);
         check_eq("bp_hold_last", 32'(bus.out_last), 32'd0);
         check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      repeat (6) step();
      check_eq("bp_idle", 32'(bus.out_valid), 32'd0);
      check_eq("bp_drain", 32'(sb_q.size()), 32'd0);

      // Back-to-back vectors with in_valid held high.
      bus.in_data  = ramp(8'h10);
      bus.in_valid = 1'b1;
      step();
      bus.in_data  = ramp(8'hA0);
      start_cnt    = beat_cnt;
      repeat (7) step();
      check_eq("b2b_last_data", 32'(bus.out_data), 32'h17);
      check_eq("b2b_last_flag", 32'(bus.out_last), 32'd1);
      check_eq("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      check_eq("b2b_next_valid", 32'(bus.out_valid), 32'd1);
      check_eq("b2b_next_data", 32'(bus.out_data), 32'hA0);
      check_eq("b2b_next_sel", 32'(bus.out_sel), 32'd0);
      repeat (8) step();
      check_eq("b2b_beats_16", 32'(beat_cnt - start_cnt), 32'd16);
      check_eq("b2b_idle", 32'(bus.out_valid), 32'd0);

      // Reset in the middle of a vector.
      bus.in_data  = ramp(8'h30);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (4) step();
      check_eq("mr_sel_reach", 32'(bus.out_sel), 32'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mr_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("mr_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("mr_out_sel", 32'(bus.out_sel), 32'd0);
      check_eq("mr_sb_flushed", 32'(sb_q.size()), 32'd0);
      bus.in_data  = ramp(8'h40);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check_eq("mr_restart_sel", 32'(bus.out_sel), 32'd0);
      check_eq("mr_restart_data", 32'(bus.out_data), 32'h40);
      repeat (8) step();
      check_eq("mr_idle", 32'(bus.out_valid), 32'd0);

`ifdef MUXN_SER_MASK_EN
      // Sparse mask: lanes 2, 5, 7 only.
      bus.in_data  = ramp(8'h50);
      bus.in_mask  = 8'b1010_0100;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.in_mask  = '1;
      check_eq("mk_first_sel", 32'(bus.out_sel), 32'd2);
      check_eq("mk_first_data", 32'(bus.out_data), 32'h52);
      step();
      check_eq("mk_second_sel", 32'(bus.out_sel), 32'd5);
      step();
      check_eq("mk_third_sel", 32'(bus.out_sel), 32'd7);
      check_eq("mk_third_last", 32'(bus.out_last), 32'd1);
      step();
      check_eq("mk_idle", 32'(bus.out_valid), 32'd0);

      // Empty mask: accepted, no beats.
      bus.in_data  = ramp(8'h60);
      bus.in_mask  = '0;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check_eq("mk0_out_valid", 32'(bus.out_valid), 32'd0);
         check_eq("mk0_in_ready", 32'(bus.in_ready), 32'd1);
      end
      bus.in_valid = 1'b0;
      bus.in_mask  = '1;
`endif

      step();
      check_eq("final_drain", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/muxn_serializer.md
Name: muxn_serializer

Overview:
- Parallel-to-serial front end that feeds an N-way mux cell (commonlib_muxn, N=8, width 8).
- Accepts one vector of N lanes via valid/ready, latches it, then drives the mux select to emit the lanes one per accepted beat, lane 0 first.
- Sits between a wide producer and a narrow, byte-serial consumer in the datapath.

Parameters:
- N, 8, number of lanes; must be a power of two, at least 2.
- WIDTH, 8, bits per lane.
- SEL_W, $clog2(N), select width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a vector on in_data.
- in_ready  output  1  block will capture in_data this cycle if in_valid is high.
- in_data  input  N*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  out_data is a valid beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  currently selected lane (mux output).
- out_sel  output  SEL_W  index of the lane currently on out_data.
- out_last  output  1  high on the final beat of a vector.

Behaviour:
- Reset (RESET high at an edge):
  - state goes to IDLE and sel to 0.
  - Any partially emitted vector is discarded.
  - Lane registers are not reset.
  - Outputs after reset: out_valid=0, out_last=0, out_sel=0, in_ready=1.
  - out_data shows lane 0 of the stale register bank; consumers ignore it while out_valid=0.
- State machine, two states:
  - IDLE: in_valid && in_ready captures all N lanes into the register bank, sets sel=0 and moves to SHIFT.
  - SHIFT, beat transfer: when out_valid && out_ready, sel increments.
  - SHIFT, last beat: when sel==N-1, the beat is the last. The state returns to IDLE, unless a new vector is captured in the same cycle (see next item).
- Back-to-back:
  - in_ready = (state==IDLE) || (state==SHIFT && out_last && out_ready).
  - in_ready is combinational on out_ready.
  - A capture coinciding with the last-beat handshake reloads the bank, sets sel=0 and stays in SHIFT.
  - Sustained throughput is N beats per N cycles with no bubble.
- Latency: vector captured at edge t gives its first beat (out_valid=1, out_sel=0) in the cycle after t.
- out_valid = (state==SHIFT); out_last = (state==SHIFT && sel==N-1).
- Hold rule: while out_valid && !out_ready, out_data, out_sel and out_last are stable and sel does not move.
- in_data is ignored when no capture occurs; in_valid may drop without a handshake.
- sel arithmetic is SEL_W bits and never wraps past N-1; return to 0 happens only via capture or reset.
- RESET has priority over every handshake in the same cycle.

Optional Feature:
- MUXN_SER_MASK_EN defined:
  - Adds input in_mask, N bits, captured together with in_data.
  - Lanes with mask bit 0 are skipped.
  - On capture, sel = lowest set bit; each advance moves sel to the next set bit above it.
  - out_last is high when no set bit lies above sel.
  - An all-zero mask is accepted, produces no beats and keeps state IDLE.
  - The in_ready equation is unchanged except that out_last uses the masked definition.
- MUXN_SER_MASK_EN undefined:
  - No in_mask port; all N lanes are always emitted in order.

Decomposition:
- Shared package muxn_ser_pkg holds:
  - the state enum (IDLE, SHIFT);
  - a function clog2-checked select width;
  - a function next_set_idx(mask, sel) used by the mask feature.
- Natural sub-module: the existing commonlib_muxn cell, instantiated with the bank as in_data_k and sel as in_sel; this block adds no mux logic of its own.
- The remaining sequential logic (FSM, sel counter, bank) stays flat in muxn_serializer.

Test Plan:
- Reset then single vector in_data lanes 0x10..0x17, out_ready tied 1:
  - out_data 0x10,0x11,...,0x17 on 8 consecutive cycles;
  - out_last only on 0x17;
  - in_ready low during beats 0-6.
- Backpressure: out_ready=0 for 3 cycles at sel=2 → out_data holds 0x12, out_sel holds 2, and no beat is lost or duplicated.
- Back-to-back: second vector 0xA0..0xA7 presented with in_valid held high → 0xA0 follows 0x17 in the very next cycle, 16 beats in 16 cycles.
- Reset mid-vector: RESET asserted at sel=4 → next cycle out_valid=0, in_ready=1; the next vector starts at lane 0.
- Mask build, in_mask=8'b1010_0100 → beats are lanes 2, 5, 7 only, with out_last on lane 7.
- Mask build, in_mask=0 → no out_valid, and in_ready stays 1.
